// File: rtl/param_register_file.sv
// General-purpose register file: two combinational read ports, one falling-edge write
// port, hardware clear sweep after reset or on request, and same-cycle write bypass.
module param_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    input  logic                  wr_enable3,
    input  logic [ADDR_WIDTH-1:0] write_addr3,
    input  logic [DATA_WIDTH-1:0] write_data3,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic                  ready
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_bypass_ok;
    logic w_wr_commit;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        r_state <= S_READY;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    if (clear_req) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                    end
                end
            endcase
        end
    end

    // A clear request on the same edge as a write wins; the write is dropped.
    assign w_bypass_ok = wr_enable3 && !clear_req;
    assign w_wr_commit = (r_state == S_READY) && w_bypass_ok &&
                         !((ZERO_REG != 0) && (write_addr3 == '0));

    // The array has no reset; the sweep is the only way it gets zeroed.
    always_ff @(negedge clk) begin
        if (r_state == S_CLEAR)
            r_mem[r_cnt] <= '0;
        else if (w_wr_commit)
            r_mem[write_addr3] <= write_data3;
    end

    function automatic logic [DATA_WIDTH-1:0] rd_port(input logic [ADDR_WIDTH-1:0] addr);
        if (!r_ready)
            return '0;
        else if ((ZERO_REG != 0) && (addr == '0))
            return '0;
        else if (w_bypass_ok && (write_addr3 == addr))
            return write_data3;
        else
            return r_mem[addr];
    endfunction

    assign read_data1 = rd_port(read_addr1);
    assign read_data2 = rd_port(read_addr2);
    assign ready      = r_ready;

endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench: three register-file configurations driven in parallel and
// compared every cycle against an array-based model of the file's behaviour.
module tb_param_register_file;
    logic        clk;
    logic        reset;
    logic        clear_req;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;

    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic [15:0] rd1_c, rd2_c;
    logic        rdy_a, rdy_b, rdy_c;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    // dut 0: 32x32 zero reg, dut 1: 32x32 ordinary r0, dut 2: 8x16 zero reg
    param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset), .clear_req(clear_req), .wr_enable3(we),
        .write_addr3(wa), .write_data3(wd), .read_addr1(ra1), .read_addr2(ra2),
        .read_data1(rd1_a), .read_data2(rd2_a), .ready(rdy_a));
    param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .clear_req(clear_req), .wr_enable3(we),
        .write_addr3(wa), .write_data3(wd), .read_addr1(ra1), .read_addr2(ra2),
        .read_data1(rd1_b), .read_data2(rd2_b), .ready(rdy_b));
    param_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1)) dut_c (
        .clk(clk), .reset(reset), .clear_req(clear_req), .wr_enable3(we),
        .write_addr3(wa[2:0]), .write_data3(wd[15:0]), .read_addr1(ra1[2:0]),
        .read_addr2(ra2[2:0]), .read_data1(rd1_c), .read_data2(rd2_c), .ready(rdy_c));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    int          depth [3] = '{32, 32, 8};
    bit          zr    [3] = '{1, 0, 1};
    int          amask [3] = '{31, 31, 7};
    logic [31:0] dmask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
    logic [31:0] m_mem [3][32];
    bit          m_rdy [3];
    int          m_left[3];

    // Clearing is modelled as "not ready for DEPTH edges, then everything is zero".
    always @(negedge clk or posedge reset) begin
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                m_rdy[d]  = 0;
                m_left[d] = depth[d];
            end else if (!m_rdy[d]) begin
                m_left[d]--;
                if (m_left[d] == 0) begin
                    m_rdy[d] = 1;
                    for (int i = 0; i < 32; i++) m_mem[d][i] = 32'h0;
                end
            end else if (clear_req) begin
                m_rdy[d]  = 0;
                m_left[d] = depth[d];
            end else if (we && !(zr[d] && ((int'(wa) & amask[d]) == 0))) begin
                m_mem[d][int'(wa) & amask[d]] = wd & dmask[d];
            end
        end
    end

    function automatic logic [31:0] exp_rd(input int d, input logic [4:0] ra);
        int a;
        a = int'(ra) & amask[d];
        if (!m_rdy[d]) return 32'h0;
        if (zr[d] && a == 0) return 32'h0;
        if (we && !clear_req && ((int'(wa) & amask[d]) == a)) return wd & dmask[d];
        return m_mem[d][a];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [31:0] g_rd1 [3];
    logic [31:0] g_rd2 [3];
    logic        g_rdy [3];
    always_comb begin
        g_rd1[0] = rd1_a;           g_rd2[0] = rd2_a;           g_rdy[0] = rdy_a;
        g_rd1[1] = rd1_b;           g_rd2[1] = rd2_b;           g_rdy[1] = rdy_b;
        g_rd1[2] = {16'h0, rd1_c};  g_rd2[2] = {16'h0, rd2_c};  g_rdy[2] = rdy_c;
    end

    // Inputs change just after posedge; outputs are compared mid-high-phase.
    always @(posedge clk) begin
        #3;
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("dut%0d ready", d), {31'h0, g_rdy[d]}, {31'h0, m_rdy[d]});
                chk($sformatf("dut%0d rd1[%0d]", d, ra1), g_rd1[d], exp_rd(d, ra1));
                chk($sformatf("dut%0d rd2[%0d]", d, ra2), g_rd2[d], exp_rd(d, ra2));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit c, input bit w, input int a, input logic [31:0] dat,
                         input int r1, input int r2);
        @(posedge clk);
        clear_req = c;
        we        = w;
        wa        = a[4:0];
        wd        = dat;
        ra1       = r1[4:0];
        ra2       = r2[4:0];
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 32'h0, int'(ra1), int'(ra2));
    endtask

    // Counts falling edges after reset release / clear accept and pins ready timing.
    task automatic sweep_edges(input string nm);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            #1;
            if (k == 12 || k == 31) chk({nm, " A ready early"}, {31'h0, rdy_a}, 32'h0);
            if (k == 32)            chk({nm, " A ready at 32"}, {31'h0, rdy_a}, 32'h1);
            if (k == 7)             chk({nm, " C ready early"}, {31'h0, rdy_c}, 32'h0);
            if (k == 8)             chk({nm, " C ready at 8"},  {31'h0, rdy_c}, 32'h1);
        end
    endtask

    initial begin
        reset = 1; clear_req = 0; we = 0; wa = 0; wd = 0; ra1 = 0; ra2 = 0;
        @(posedge clk);
        #3;
        chk("reset ready", {31'h0, rdy_a}, 32'h0);
        chk("reset rd1", rd1_a, 32'h0);
        chk("reset rd2", rd2_a, 32'h0);
        chk_en = 1;
        @(posedge clk);
        reset = 0;
        idle(36);
        for (int i = 0; i < 32; i++) drive(0, 1, i, $urandom, i, 31 - i);

        // reset sweep over garbage contents
        @(posedge clk); reset = 1;
        @(posedge clk); reset = 0;
        sweep_edges("reset sweep");
        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 32'h0, a, 31 - a);
            #3;
            chk("swept rd1", rd1_a, 32'h0);
            chk("swept rd2", rd2_a, 32'h0);
        end

        // write/read and zero register
        drive(0, 1, 5, 32'hDEAD_BEEF, 0, 0);
        drive(0, 0, 0, 32'h0, 5, 5);
        #3;
        chk("r5 rd1", rd1_a, 32'hDEAD_BEEF);
        chk("r5 rd2", rd2_a, 32'hDEAD_BEEF);
        chk("C r5 rd1", {16'h0, rd1_c}, 32'h0000_BEEF);
        drive(0, 1, 0, 32'h1234, 0, 0);
        drive(0, 0, 0, 32'h0, 0, 0);
        #3;
        chk("A r0", rd1_a, 32'h0);
        chk("B r0", rd1_b, 32'h1234);
        chk("C r0", {16'h0, rd1_c}, 32'h0);

        // bypass
        drive(0, 1, 8, 32'h0808_0808, 0, 0);
        drive(0, 1, 7, 32'hA5A5_A5A5, 7, 8);
        #3;
        chk("A bypass rd1", rd1_a, 32'hA5A5_A5A5);
        chk("A old r8 rd2", rd2_a, 32'h0808_0808);
        chk("B old r8 rd2", rd2_b, 32'h0808_0808);
        chk("C bypass rd1", {16'h0, rd1_c}, 32'h0000_A5A5);
        chk("C r0 rd2", {16'h0, rd2_c}, 32'h0);

        // clear request with simultaneous write
        drive(0, 1, 3, 32'h55, 3, 3);
        drive(1, 1, 3, 32'h99, 3, 3);
        #3;
        chk("no bypass on clear", rd1_a, 32'h55);
        @(negedge clk);
        #1;
        chk("ready drops on clear", {31'h0, rdy_a}, 32'h0);
        clear_req = 0; we = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            #1;
            if (k == 31) chk("clear A ready early", {31'h0, rdy_a}, 32'h0);
            if (k == 32) chk("clear A ready at 32", {31'h0, rdy_a}, 32'h1);
        end
        @(posedge clk);
        #3;
        chk("r3 after clear", rd1_a, 32'h0);

        // writes ignored while clearing
        drive(1, 0, 0, 32'h0, 31, 31);
        @(negedge clk);
        #1;
        clear_req = 0;
        repeat (10) @(negedge clk);
        drive(0, 1, 31, 32'hFF, 31, 31);
        #3;
        chk("r31 during clear", rd1_a, 32'h0);
        idle(25);
        #3;
        chk("r31 after clear", rd1_a, 32'h0);

        // mid-sweep reset restarts the sweep
        @(posedge clk); reset = 1;
        @(posedge clk); reset = 0;
        repeat (20) @(negedge clk);
        @(posedge clk); reset = 1;
        @(posedge clk); reset = 0;
        sweep_edges("mid reset");

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 40) == 0, $urandom % 2, $urandom % 32, $urandom,
                  $urandom % 32, $urandom % 32);
            reset = (($urandom % 300) == 0);
        end
        reset = 0;
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised general-purpose register file for the MIPS datapath: two combinational read ports, one write port committed on the falling clock edge, and configurable width, depth and hardwired zero register. It adds three things the fixed 32x32 file lacks: an asynchronous reset, a hardware clear sweep with a `ready` flag, and same-cycle write-to-read bypass. It sits between the decode stage (read ports) and the write-back stage (write port).

## Interface
- `DATA_WIDTH`, 32: register width in bits.
- `ADDR_WIDTH`, 5: address width; depth `DEPTH = 2**ADDR_WIDTH`.
- `ZERO_REG`, 1: 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary.

Ports:
- `clk` input 1: clock; all sequential logic acts on the falling edge.
- `reset` input 1: asynchronous, active-high reset.
- `clear_req` input 1: request a full clear sweep; sampled on the falling edge.
- `wr_enable3` input 1: write enable.
- `write_addr3` input ADDR_WIDTH: write address.
- `write_data3` input DATA_WIDTH: write data.
- `read_addr1` input ADDR_WIDTH: port 1 read address.
- `read_addr2` input ADDR_WIDTH: port 2 read address.
- `read_data1` output DATA_WIDTH: port 1 read data (combinational).
- `read_data2` output DATA_WIDTH: port 2 read data (combinational).
- `ready` output 1: 1 = file is initialised and accepts writes.

## Operation
- The state machine has two states, CLEAR and READY, and a sweep counter `cnt` of ADDR_WIDTH bits.
- `reset` high puts the block in state CLEAR with `cnt` = 0 and `ready` = 0. This takes effect immediately and does not wait for a clock edge.
- CLEAR, on each falling edge:
  - write 0 to `mem[cnt]`, then increment `cnt`.
  - On the edge where `cnt` = DEPTH-1 is written, go to READY and set `ready` = 1.
  - `wr_enable3` and `clear_req` are ignored.
- READY, on each falling edge:
  - If `clear_req` = 1, go to CLEAR, set `cnt` = 0 and `ready` = 0. Any write on that same edge is dropped, because clear wins.
  - Otherwise, if `wr_enable3` = 1, write `mem[write_addr3] <= write_data3`. If ZERO_REG = 1 and `write_addr3` = 0, the write is discarded.
- Read port n (the same rule applies to both ports independently), evaluated in this priority order:
  1. `ready` = 0: output 0.
  2. ZERO_REG = 1 and `read_addrn` = 0: output 0.
  3. Bypass: `wr_enable3` = 1, `clear_req` = 0 and `write_addr3` = `read_addrn`: output `write_data3`.
  4. Otherwise output `mem[read_addrn]`.
- Both ports may read the same address. All addresses are in range because DEPTH = 2**ADDR_WIDTH, so there is no out-of-range case.
- Memory contents are not reset directly; they are zeroed only by the sweep.

## Timing
- Reset values: `ready` = 0, `read_data1` = 0, `read_data2` = 0, state = CLEAR, `cnt` = 0.
- After `reset` deasserts, `ready` rises on the DEPTH-th falling edge. With defaults that is edge 32.
- `clear_req` accepted on falling edge k: `ready` is 0 immediately after edge k, and returns to 1 on edge k+DEPTH.
- `reset` asserted mid-sweep: the sweep restarts from `cnt` = 0 after release. Partially cleared contents are irrelevant because the full sweep is repeated.
- Write latency: data is visible through the bypass in the same cycle, combinationally. It is visible from the array after the falling edge that commits it.
- Read latency: 0 cycles, combinational from address to data.
- `ready` is registered and changes only on a falling edge or on assertion of `reset`.

## Test plan
1. **Reset sweep.** Assert `reset`, preload garbage through backdoor, release `reset`.
   - `ready` = 0 for 31 falling edges and 1 at edge 32.
   - All 32 registers then read 0.
2. **Write/read and zero register.**
   - Write 0xDEADBEEF to r5, then read r5 on both ports: 0xDEADBEEF.
   - Write 0x1234 to r0, then read r0: 0 with ZERO_REG = 1.
   - With ZERO_REG = 0 the same read of r0 returns 0x1234.
3. **Bypass.** `wr_enable3` = 1, `write_addr3` = 7, `write_data3` = 0xA5A5A5A5, `read_addr1` = 7, `read_addr2` = 8, before the falling edge.
   - `read_data1` = 0xA5A5A5A5 in the same cycle.
   - `read_data2` shows the old value of r8.
4. **Clear request with simultaneous write.** r3 = 0x55, then pulse `clear_req` with a write of 0x99 to r3 on the same edge.
   - `ready` drops to 0.
   - After 32 edges `ready` = 1 and r3 = 0 (write dropped).
5. **Writes ignored while clearing.** During CLEAR, write 0xFF to r31 at `cnt` = 10.
   - `read_data1` = 0 throughout.
   - After `ready` rises, r31 = 0.
6. **Mid-sweep reset and parameters.**
   - Pulse `reset` at `cnt` = 20: `ready` rises 32 edges after release, not 12.
   - Repeat tests 1–3 with DATA_WIDTH = 16, ADDR_WIDTH = 3: `ready` at edge 8, bypass correct on 16 bits.
